// File: rtl/bx_link_host_if.sv
// Command/response bundle between fabric logic and one bx_link_host.
// master: fabric side issuing commands; slave: the link host.
// Handshake: a command transfers on any clk edge where cmd_valid & cmd_ready;
// cmd_* fields must be stable while cmd_valid is high. rsp_valid is a
// one-cycle strobe with no back-pressure; rsp_rdata/rsp_err/rsp_timeout
// hold their values until the next rsp_valid.
interface bx_link_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/bx_link_host.sv
// Host-side initiator for the 4-bit bidirectional nibble link to an mSoC.
// Serialises one register read/write per command, turns the bus around,
// waits for ACK/NAK (bounded by TIMEOUT) and returns a single response.
// Optional feature: define BX_LINK_PARITY_EN to add a host PAR nibble before
// TA1 and a responder RD_PAR nibble after read data.
module bx_link_host #(
    parameter int unsigned TIMEOUT = 16   // WAIT_ACK cycles, legal 2..255
) (
    input  logic           clk,
    input  logic           c_sys_rst,
    bx_link_host_if.slave  link,
    inout  wire  [3:0]     b_data_io,
    output logic [3:0]     dbg_state_o
);

    localparam logic [3:0] NIB_IDLE   = 4'h0;
    localparam logic [3:0] NIB_SOF_WR = 4'h9;
    localparam logic [3:0] NIB_SOF_RD = 4'hA;
    localparam logic [3:0] NIB_ACK    = 4'h5;
    localparam logic [3:0] NIB_NAK    = 4'hE;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SOF      = 4'd1,
        S_ADDR     = 4'd2,
        S_DHI      = 4'd3,
        S_DLO      = 4'd4,
`ifdef BX_LINK_PARITY_EN
        S_PAR      = 4'd5,
`endif
        S_TA1      = 4'd6,
        S_WAIT_ACK = 4'd7,
        S_RD_HI    = 4'd8,
        S_RD_LO    = 4'd9,
`ifdef BX_LINK_PARITY_EN
        S_RD_PAR   = 4'd10,
`endif
        S_TA2      = 4'd11
    } state_t;

    // Last host-driven state of a frame hands over to PAR or straight to TA1.
`ifdef BX_LINK_PARITY_EN
    localparam state_t S_FRAME_END = S_PAR;
`else
    localparam state_t S_FRAME_END = S_TA1;
`endif

    state_t     state_q, state_d;
    logic       write_q, write_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] rd_hi_q, rd_hi_d;
`ifdef BX_LINK_PARITY_EN
    logic [3:0] rd_lo_q, rd_lo_d;
`endif
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_timeout_q, rsp_timeout_d;
    logic       drive_en;
    logic [3:0] drive_val;

    // Bus drive comes only from registered state, so the enable moves on edges.
    assign b_data_io        = drive_en ? drive_val : 4'bzzzz;
    assign link.rsp_rdata   = rsp_rdata_q;
    assign link.rsp_err     = rsp_err_q;
    assign link.rsp_timeout = rsp_timeout_q;
    assign dbg_state_o      = state_q;

    // State and datapath registers; reset aborts any frame without a response.
    always_ff @(posedge clk) begin
        if (c_sys_rst) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            addr_q        <= 4'h0;
            wdata_q       <= 8'h00;
            cnt_q         <= 8'h00;
            rd_hi_q       <= 4'h0;
`ifdef BX_LINK_PARITY_EN
            rd_lo_q       <= 4'h0;
`endif
            rsp_rdata_q   <= 8'h00;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rd_hi_q       <= rd_hi_d;
`ifdef BX_LINK_PARITY_EN
            rd_lo_q       <= rd_lo_d;
`endif
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state, bus drive and handshake outputs; response fields load on TA2 entry.
    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        rd_hi_d        = rd_hi_q;
`ifdef BX_LINK_PARITY_EN
        rd_lo_d        = rd_lo_q;
`endif
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        rsp_timeout_d  = rsp_timeout_q;
        drive_en       = 1'b0;
        drive_val      = NIB_IDLE;
        link.cmd_ready = 1'b0;
        link.rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                drive_en       = 1'b1;
                link.cmd_ready = 1'b1;
                if (link.cmd_valid) begin
                    write_d = link.cmd_write;
                    addr_d  = link.cmd_addr;
                    wdata_d = link.cmd_wdata;
                    state_d = S_SOF;
                end
            end
            S_SOF: begin
                drive_en  = 1'b1;
                drive_val = write_q ? NIB_SOF_WR : NIB_SOF_RD;
                state_d   = S_ADDR;
            end
            S_ADDR: begin
                drive_en  = 1'b1;
                drive_val = addr_q;
                state_d   = write_q ? S_DHI : S_FRAME_END;
            end
            S_DHI: begin
                drive_en  = 1'b1;
                drive_val = wdata_q[7:4];
                state_d   = S_DLO;
            end
            S_DLO: begin
                drive_en  = 1'b1;
                drive_val = wdata_q[3:0];
                state_d   = S_FRAME_END;
            end
`ifdef BX_LINK_PARITY_EN
            S_PAR: begin
                drive_en  = 1'b1;
                drive_val = (write_q ? NIB_SOF_WR : NIB_SOF_RD) ^ addr_q
                          ^ (write_q ? (wdata_q[7:4] ^ wdata_q[3:0]) : 4'h0);
                state_d   = S_TA1;
            end
`endif
            S_TA1: begin
                cnt_d   = 8'h00;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (b_data_io == NIB_ACK) begin
                    if (write_q) begin
                        rsp_rdata_d   = 8'h00;
                        rsp_err_d     = 1'b0;
                        rsp_timeout_d = 1'b0;
                        state_d       = S_TA2;
                    end else begin
                        state_d = S_RD_HI;
                    end
                end else if (b_data_io == NIB_NAK) begin
                    rsp_rdata_d   = 8'h00;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_TA2;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rsp_rdata_d   = 8'h00;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_TA2;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RD_HI: begin
                rd_hi_d = b_data_io;
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
`ifdef BX_LINK_PARITY_EN
                rd_lo_d       = b_data_io;
                state_d       = S_RD_PAR;
`else
                rsp_rdata_d   = {rd_hi_q, b_data_io};
                rsp_err_d     = 1'b0;
                rsp_timeout_d = 1'b0;
                state_d       = S_TA2;
`endif
            end
`ifdef BX_LINK_PARITY_EN
            S_RD_PAR: begin
                // Data is reported even when the responder's parity disagrees.
                rsp_rdata_d   = {rd_hi_q, rd_lo_q};
                rsp_err_d     = (b_data_io != (NIB_ACK ^ rd_hi_q ^ rd_lo_q));
                rsp_timeout_d = 1'b0;
                state_d       = S_TA2;
            end
`endif
            S_TA2: begin
                link.rsp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bx_link_host.sv
// Self-checking bench for bx_link_host: a randomised responder on the nibble
// link and a frame-level reference model that derives expected nibbles,
// latency and response fields from the link protocol rules.
module tb_bx_link_host;

    localparam int TIMEOUT = 16;
`ifdef BX_LINK_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int K_ACK    = 0;
    localparam int K_NAK    = 1;
    localparam int K_SILENT = 2;

    logic       clk;
    logic       c_sys_rst;
    wire  [3:0] b_data_io;
    logic [3:0] dbg_state;
    logic       resp_oe;
    logic [3:0] resp_val;
    int         checks;
    int         errors;

    bx_link_host_if link();

    bx_link_host #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .c_sys_rst   (c_sys_rst),
        .link        (link),
        .b_data_io   (b_data_io),
        .dbg_state_o (dbg_state)
    );

    // Responder side of the link.
    assign b_data_io = resp_oe ? resp_val : 4'bzzzz;

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] rand_noise();
        logic [3:0] v;
        v = 4'(($urandom_range(0, 15)));
        while (v == 4'h5 || v == 4'hE) v = 4'(($urandom_range(0, 15)));
        return v;
    endfunction

    // One command end to end. Called just after a negedge with the host idle.
    // noise[4]=1 selects random filler nibbles, otherwise noise[3:0] is used.
    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [7:0] wdata,
                           input int n_noise, input int kind, input logic [7:0] rdata,
                           input bit bad_par, input logic [4:0] noise);
        logic [3:0] exp_q[$];
        logic [3:0] par;
        logic [3:0] rd_par;
        logic [7:0] exp_rdata;
        logic       exp_err;
        logic       exp_to;
        int         flen;
        int         wait_len;
        int         exp_lat;
        int         w;

        // Reference model: frame contents, latency and response.
        exp_q = {};
        exp_q.push_back(wr ? 4'h9 : 4'hA);
        exp_q.push_back(addr);
        if (wr) begin
            exp_q.push_back(wdata[7:4]);
            exp_q.push_back(wdata[3:0]);
        end
        if (PAR == 1) begin
            par = 4'h0;
            foreach (exp_q[i]) par = par ^ exp_q[i];
            exp_q.push_back(par);
        end
        flen      = exp_q.size();
        wait_len  = (kind == K_SILENT) ? TIMEOUT : n_noise + 1;
        exp_lat   = flen + 1 + wait_len + ((!wr && kind == K_ACK) ? 2 + PAR : 0) + 1;
        exp_rdata = (!wr && kind == K_ACK) ? rdata : 8'h00;
        rd_par    = 4'h5 ^ rdata[7:4] ^ rdata[3:0];
        if (bad_par) rd_par = rd_par ^ 4'h6;
        exp_err   = (kind != K_ACK) || (PAR == 1 && !wr && bad_par);
        exp_to    = (kind == K_SILENT);

        link.cmd_valid = 1'b1;
        link.cmd_write = wr;
        link.cmd_addr  = addr;
        link.cmd_wdata = wdata;
        #1;
        checks++;
        if (link.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_c0: got %b want 1", link.cmd_ready);
        end
        @(posedge clk);

        for (int cyc = 1; cyc <= exp_lat + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) link.cmd_valid = 1'b0;
            w        = cyc - flen - 1;
            resp_oe  = 1'b0;
            resp_val = 4'h0;
            if (cyc == flen + 1 || cyc == exp_lat) begin
                // Responder parks 0 on turnarounds: a host still driving shows non-zero.
                resp_oe = 1'b1;
            end else if (w >= 1 && cyc < exp_lat) begin
                resp_oe = 1'b1;
                if (kind == K_SILENT || w <= n_noise)
                    resp_val = noise[4] ? rand_noise() : noise[3:0];
                else if (w == n_noise + 1) resp_val = (kind == K_ACK) ? 4'h5 : 4'hE;
                else if (w == n_noise + 2) resp_val = rdata[7:4];
                else if (w == n_noise + 3) resp_val = rdata[3:0];
                else                       resp_val = rd_par;
            end
            #1;
            if (cyc <= flen) begin
                checks++;
                if (b_data_io !== exp_q[cyc-1]) begin
                    errors++;
                    $display("FAIL frame_nibble c%0d: got %h want %h", cyc, b_data_io, exp_q[cyc-1]);
                end
            end
            if (cyc == flen + 1 || cyc == exp_lat) begin
                checks++;
                if (b_data_io !== 4'h0) begin
                    errors++;
                    $display("FAIL turnaround_release c%0d: bus %h want 0", cyc, b_data_io);
                end
            end
            if (cyc == exp_lat + 1) begin
                checks++;
                if (b_data_io !== 4'h0) begin
                    errors++;
                    $display("FAIL idle_bus c%0d: got %h want 0", cyc, b_data_io);
                end
            end
            checks++;
            if (link.rsp_valid !== 1'(cyc == exp_lat)) begin
                errors++;
                $display("FAIL rsp_valid c%0d: got %b want %b (latency %0d)", cyc, link.rsp_valid, cyc == exp_lat, exp_lat);
            end
            checks++;
            if (link.cmd_ready !== 1'(cyc == exp_lat + 1)) begin
                errors++;
                $display("FAIL cmd_ready c%0d: got %b want %b", cyc, link.cmd_ready, cyc == exp_lat + 1);
            end
            if (cyc >= exp_lat) begin
                checks++;
                if (link.rsp_rdata !== exp_rdata || link.rsp_err !== exp_err || link.rsp_timeout !== exp_to) begin
                    errors++;
                    $display("FAIL rsp_fields c%0d: rdata %h err %b to %b want %h %b %b",
                             cyc, link.rsp_rdata, link.rsp_err, link.rsp_timeout, exp_rdata, exp_err, exp_to);
                end
            end
        end
        resp_oe = 1'b0;
    endtask

    task automatic test_reset();
        c_sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        c_sys_rst = 1'b0;
        #1;
        checks++;
        if (link.cmd_ready !== 1'b1 || link.rsp_valid !== 1'b0 || link.rsp_rdata !== 8'h00 ||
            link.rsp_err !== 1'b0 || link.rsp_timeout !== 1'b0 || b_data_io !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: ready %b valid %b rdata %h err %b to %b bus %h want 1 0 00 0 0 0",
                     link.cmd_ready, link.rsp_valid, link.rsp_rdata, link.rsp_err, link.rsp_timeout, b_data_io);
        end
    endtask

    task automatic test_write_ack();
        @(negedge clk);
        run_txn(1'b1, 4'h3, 8'hC7, 0, K_ACK, 8'h00, 1'b0, 5'h00);
    endtask

    task automatic test_read_ack();
        @(negedge clk);
        run_txn(1'b0, 4'hB, 8'h00, 2, K_ACK, 8'h6D, 1'b0, 5'h00);
    endtask

    task automatic test_read_nak();
        @(negedge clk);
        run_txn(1'b0, 4'h7, 8'h00, 1, K_NAK, 8'h00, 1'b0, 5'h10);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        run_txn(1'b1, 4'h4, 8'h5A, 0, K_SILENT, 8'h00, 1'b0, 5'h03);
        run_txn(1'b1, 4'h4, 8'hA5, 0, K_ACK, 8'h00, 1'b0, 5'h00);
    endtask

    task automatic test_reset_mid_frame();
        bit saw_valid;
        @(negedge clk);
        link.cmd_valid = 1'b1;
        link.cmd_write = 1'b1;
        link.cmd_addr  = 4'h2;
        link.cmd_wdata = 8'hB4;
        @(posedge clk);
        @(negedge clk);
        link.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (b_data_io !== 4'hB) begin
            errors++;
            $display("FAIL mid_frame_dhi: got %h want b", b_data_io);
        end
        c_sys_rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (b_data_io !== 4'h0 || link.cmd_ready !== 1'b1 || link.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: bus %h ready %b valid %b want 0 1 0", b_data_io, link.cmd_ready, link.rsp_valid);
        end
        c_sys_rst = 1'b0;
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (link.rsp_valid === 1'b1) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL aborted_rsp: got rsp_valid after reset want none");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_txn(1'b0, 4'h1, 8'h00, 0, K_ACK, 8'h3C, 1'b0, 5'h10);
        run_txn(1'b1, 4'hF, 8'h81, 3, K_ACK, 8'h00, 1'b0, 5'h10);
        run_txn(1'b1, 4'h0, 8'h00, 0, K_NAK, 8'h00, 1'b0, 5'h10);
    endtask

    task automatic test_random();
        int k;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            k = $urandom_range(0, 9);
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                    $urandom_range(0, 5), (k == 0) ? K_SILENT : (k < 3) ? K_NAK : K_ACK,
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 5'h10);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

`ifdef BX_LINK_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        run_txn(1'b1, 4'h1, 8'h22, 0, K_ACK, 8'h00, 1'b0, 5'h00);
        run_txn(1'b0, 4'h9, 8'h00, 1, K_ACK, 8'hE1, 1'b1, 5'h00);
        run_txn(1'b0, 4'h9, 8'h00, 0, K_ACK, 8'h1E, 1'b0, 5'h00);
    endtask
`endif

    initial begin
        checks         = 0;
        errors         = 0;
        resp_oe        = 1'b0;
        resp_val       = 4'h0;
        c_sys_rst      = 1'b1;
        link.cmd_valid = 1'b0;
        link.cmd_write = 1'b0;
        link.cmd_addr  = 4'h0;
        link.cmd_wdata = 8'h00;
        test_reset();
        test_write_ack();
        test_read_ack();
        test_read_nak();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef BX_LINK_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bx_link_host.md
# bx_link_host

Host-side initiator for the 4-bit bidirectional nibble link that connects the fabric to each mSoC instance's `bN_data_io` port. It accepts single register read/write commands from fabric logic and serialises them as nibble frames. It turns the bus around, waits for the mSoC responder's acknowledge, and captures read data. It returns one response per command, flagging errors and timeouts. One instance sits on each of the four SoC links under the FPGA top, clocked from the PLL `clk` and reset by `c_sys_rst`.

## Interface
- TIMEOUT, 16, cycles to wait for ACK/NAK after turnaround; legal range 2..255
- clk  in  1  system clock (PLL output)
- c_sys_rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  4  register address
- cmd_wdata  in  8  write data (ignored for reads)
- rsp_valid  out  1  single-cycle response strobe
- rsp_rdata  out  8  read data, valid with rsp_valid on reads; 8'h00 otherwise
- rsp_err  out  1  NAK, timeout or parity failure
- rsp_timeout  out  1  no ACK/NAK within TIMEOUT
- b_data_io  inout  4  nibble link to the mSoC

## Operation
- Nibble codes: idle 4'h0, SOF_WR 4'h9, SOF_RD 4'hA, ACK 4'h5, NAK 4'hE.
- The host owns the bus outside frames and drives 4'h0. It releases the bus (Z) only in TA1, WAIT_ACK, RD_HI, RD_LO, RD_PAR and TA2.
- States: IDLE -> SOF -> ADDR -> (write: DHI -> DLO) -> [PAR] -> TA1 -> WAIT_ACK -> (read ACK: RD_HI -> RD_LO -> [RD_PAR]) -> TA2 -> IDLE.
- IDLE: cmd_ready=1. On a handshake, capture cmd_write, cmd_addr and cmd_wdata, then go to SOF.
- SOF drives SOF_WR or SOF_RD. ADDR drives cmd_addr. DHI drives wdata[7:4] and DLO drives wdata[3:0].
- TA1: bus released for one cycle. The timeout counter clears to 0.
- WAIT_ACK: sample b_data_io each cycle.
  - ACK: a write goes to TA2 with success; a read goes to RD_HI.
  - NAK: go to TA2 with rsp_err=1.
  - Any other nibble is ignored and the counter increments.
  - Counter == TIMEOUT-1 with no ACK/NAK: go to TA2 with rsp_err=1 and rsp_timeout=1.
- RD_HI and RD_LO sample rdata[7:4] and rdata[3:0].
- TA2: bus still released. rsp_valid=1 for exactly this cycle. The next state is IDLE, where the host drives 4'h0 again.
- Only one command is outstanding. cmd_ready=0 from SOF through TA2.
- Reset mid-frame: the next edge returns to IDLE with b_data_io driven 4'h0. No rsp_valid is issued for the aborted command.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_rdata=8'h00, rsp_err=0, rsp_timeout=0, b_data_io driven 4'h0, timeout counter 0.
- Cycle numbering: handshake in cycle 0 means SOF is on the bus in cycle 1.
- Write without parity: SOF c1, ADDR c2, DHI c3, DLO c4, TA1 c5, WAIT_ACK from c6.
  - An ACK sampled in cycle k gives TA2/rsp_valid in cycle k+1 and cmd_ready=1 in cycle k+2.
  - Minimum command-to-response latency is 7 cycles.
- Read without parity: SOF c1, ADDR c2, TA1 c3, WAIT_ACK from c4.
  - With ACK in cycle k: RD_HI k+1, RD_LO k+2, rsp_valid k+3.
- Timeout case: ACK/NAK absent for TIMEOUT WAIT_ACK cycles, so rsp_valid occurs in cycle TA1+TIMEOUT+1.
- b_data_io is sampled at the rising clk edge ending each receive cycle. Output enable changes only at clk edges.
- rsp_rdata and the error flags hold their values until the next rsp_valid.

## Configuration
- BX_LINK_PARITY_EN defined:
  - The host inserts a PAR cycle before TA1, driving the XOR of all nibbles it drove from SOF onward.
  - On ACKed reads, RD_PAR follows RD_LO. The host samples the responder's parity nibble and compares it against ACK ^ rdata[7:4] ^ rdata[3:0].
  - On a mismatch, rsp_err=1 and rsp_timeout=0, and rsp_rdata is still reported.
  - Write and read frames each grow by one cycle per parity nibble.
- Macro undefined: no PAR or RD_PAR states exist and the latencies in Timing apply exactly.

## Test plan
- Write addr 4'h3, data 8'hC7; responder ACKs at c6 -> bus carries 9,3,C,7, then Z at c5. rsp_valid in c7 with rsp_err=0. cmd_ready high again in c8.
- Read addr 4'hB; responder drives 0 for 2 cycles, then 5, 4'h6, 4'hD -> rsp_rdata=8'h6D and rsp_err=0. rsp_valid occurs 3 cycles after the ACK cycle.
- Read; responder drives NAK 4'hE -> rsp_valid with rsp_err=1, rsp_timeout=0, rsp_rdata=8'h00.
- Write, TIMEOUT=16; responder silent (drives 4'h3 noise) -> rsp_valid 17 cycles after TA1 with rsp_err=1 and rsp_timeout=1. The next command is accepted normally.
- c_sys_rst asserted during DHI -> the next cycle is IDLE with bus driven 4'h0 and cmd_ready=1. No rsp_valid is issued.
- BX_LINK_PARITY_EN defined:
  - Write 4'h1/8'h22 -> PAR nibble 9^1^2^2 = 4'h8 appears before TA1.
  - Read with a wrong responder parity -> rsp_err=1.
